// File: rtl/z_run_pkg.sv
// Shared types and default widths for the z-run logger.
package z_run_pkg;

    localparam int LEN_W_DEF  = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [LEN_W_DEF-1:0] len;
        logic                 sat;
    } z_run_rec_t;

endpackage

// File: rtl/z_run_fifo.sv
// Show-ahead FIFO whose head is held in a register, so the output keeps its
// last value after the final pop instead of exposing a stale memory slot.
module z_run_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is still accepted.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
            // The next head comes from memory if one is already stored, otherwise from the incoming push.
            if (do_pop && (count > (AW+1)'(1))) begin
                head <= mem[rd_ptr + AW'(1)];
            end else if (do_push && (empty || do_pop)) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/z_run_logger.sv
// Measures each contiguous run of z=1 and queues {length, saturated} records,
// counting records that arrive while the queue is full.
module z_run_logger
    import z_run_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              z,
    output logic              in_run,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_sat,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             sat;
    } rec_t;

    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_t              state;
    state_t              next_state;
    logic [LEN_W-1:0]    run_cnt;
    logic [LEN_W-1:0]    next_cnt;
    logic                sat_r;
    logic                next_sat;
    logic                rec_done;
    rec_t                new_rec;
    rec_t                head_rec;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                pop;

    always_comb begin
        next_state = state;
        next_cnt   = run_cnt;
        next_sat   = sat_r;
        rec_done   = 1'b0;
        case (state)
            IDLE: begin
                if (z) begin
                    next_state = RUN;
                    next_cnt   = LEN_W'(1);
                    next_sat   = 1'b0;
                end
            end
            RUN: begin
                if (z) begin
                    if (run_cnt != LEN_MAX) begin
                        next_cnt = run_cnt + LEN_W'(1);
                    end else begin
                        next_sat = 1'b1;
                    end
                end else begin
                    rec_done   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            run_cnt  <= '0;
            sat_r    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= next_state;
            run_cnt <= next_cnt;
            sat_r   <= next_sat;
            if (rec_done && fifo_full && !pop && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    assign new_rec   = '{len: run_cnt, sat: sat_r};
    assign pop       = out_ready && !fifo_empty;
    assign in_run    = (state == RUN);
    assign out_valid = (fifo_count != '0);
    assign out_len   = head_rec.len;
    assign out_sat   = head_rec.sat;

    z_run_fifo #(
        .WIDTH(LEN_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rec_done),
        .push_data(new_rec),
        .pop      (pop),
        .head     (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
